// File: rtl/booth_seq_mul_if.sv
// Operand/product handshake bundle for the sequential Booth multiplier.
// The master side supplies operands and consumes products; the slave side is the multiplier.
interface booth_seq_mul_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/booth_seq_mul.sv
// Sequential 8x8 signed radix-2 Booth multiplier, one step per cycle through a
// shared 8-bit add/sub; delivers a 16-bit signed product over valid/ready.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | eight Booth add/sub + arithmetic-shift steps
// DONE  | product presented, out_valid held until taken
module booth_seq_mul #(
  parameter bit SKIP_ZERO = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  booth_seq_mul_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  reg_a, reg_q, reg_m;
  logic        q_m1;
  logic [2:0]  count;
  logic        accept, zero_hit, addsuben;
  logic [8:0]  s;
  logic [8:0]  sum9;

  assign accept   = bus.in_valid && (state == IDLE);
  assign zero_hit = SKIP_ZERO && ((bus.a_in == 8'd0) || (bus.b_in == 8'd0));

  // Shared adder: S = A + (B ^ sub) + sub, S[8] is the carry-out.
  always_comb begin
    s = {1'b0, reg_a} + {1'b0, reg_m ^ {8{addsuben}}} + {8'd0, addsuben};
  end

  // Carry-out is not the sign; rebuild the true 9-bit sign so A-(-128) is exact.
  always_comb begin
    sum9 = {reg_a[7], reg_a};
    if (reg_q[0] ^ q_m1)
      sum9 = {reg_a[7] ^ (reg_m[7] ^ addsuben) ^ s[8], s[7:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = zero_hit ? DONE : RUN;
      RUN:     if (count == 3'd7) state_nxt = DONE;
      DONE:    if (bus.out_valid && bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (state == IDLE);
    bus.busy     = (state != IDLE);
    addsuben     = (state == RUN) && reg_q[0] && !q_m1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_a         <= '0;
      reg_q         <= '0;
      reg_m         <= '0;
      q_m1          <= 1'b0;
      count         <= '0;
      bus.out_valid <= 1'b0;
      bus.product   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            reg_m <= bus.a_in;
            reg_q <= zero_hit ? 8'd0 : bus.b_in;
            reg_a <= '0;
            q_m1  <= 1'b0;
            count <= '0;
          end
        end
        RUN: begin
          reg_a <= sum9[8:1];
          reg_q <= {sum9[0], reg_q[7:1]};
          q_m1  <= reg_q[0];
          count <= count + 3'd1;
          if (count == 3'd7) begin
            bus.out_valid <= 1'b1;
            bus.product   <= {sum9[8:1], sum9[0], reg_q[7:1]};
          end
        end
        DONE: begin
          // Zero-skip path enters DONE with out_valid still low; raise it one cycle later.
          if (!bus.out_valid) begin
            bus.out_valid <= 1'b1;
            bus.product   <= {reg_a, reg_q};
          end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
